// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory responder and its storage array.
package mem_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_t;

    typedef logic [DEF_DATA_W-1:0] mem_data_t;
    typedef logic [DEF_ADDR_W-1:0] mem_addr_t;

endpackage

// File: rtl/mem_array.sv
// Storage flops for the responder: one synchronous write port, one combinational read port.
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: every word is cleared on reset, so this array maps to flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts bus writes in one cycle, returns reads after RD_WAIT wait states,
// flags protocol errors and counts accepted accesses.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RD_WAIT = 0,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic [3:0] WAIT_INIT = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;

    mem_state_t        state, next_state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rdata;

    logic wr_accept;
    logic rd_accept;
    logic err_set;

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_accept),
        .waddr (addr),
        .wdata (data_in),
        .raddr (addr_q),
        .rdata (rdata)
    );

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        next_state = state;
        wr_accept  = 1'b0;
        rd_accept  = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (read && write) begin
                    err_set = 1'b1;
                end else if (write) begin
                    wr_accept = 1'b1;
                end else if (read) begin
                    rd_accept  = 1'b1;
                    next_state = (RD_WAIT == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                err_set = read || write;
                if (wait_cnt == 4'd0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                err_set    = read || write;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            addr_q   <= '0;
        end else if (rd_accept) begin
            wait_cnt <= WAIT_INIT;
            addr_q   <= addr;
        end else if (state == WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // The word is sampled out of RESP, so data_valid rises RD_WAIT+1 edges after the request edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= (state == RESP);
            if (state == RESP) begin
                data_out <= rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err      <= 1'b0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (err_set) begin
                err <= 1'b1;
            end
            if (rd_accept) begin
                rd_count <= rd_count + CNT_W'(1'b1);
            end
            if (wr_accept) begin
                wr_count <= wr_count + CNT_W'(1'b1);
            end
        end
    end

endmodule
